return_addr_stack: RTL and testbench

Return-address stack for the frontend branch predictor. It consumes the call/return classification produced by the instruction scanner: pushes the fall-through address on a call and supplies the predicted target on a return. It is a fixed-depth shift-register stack with one push/pop port and flush. Its registered top-of-stack is read combinationally by the next-PC logic.

---
 rtl/return_addr_stack.sv | 118 +++++++++++
 tb/tb_return_addr_stack.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/return_addr_stack.sv
// Return-address stack for the frontend branch predictor.
//
// This is a fixed-depth shift-register stack. Entry 0 is the top of the stack.
// A call pushes the fall-through address, and a return pops the predicted target.
// A push and a pop in the same cycle replace the top entry in place.
// Every output comes straight from a flop, so the next-PC logic sees no
// combinational path from the inputs.
//
// Ports:
//   clk_i        clock; all state updates on the rising edge
//   rst_i        synchronous, active-high reset
//   flush_bp_i   invalidate the whole stack; push/pop in the same cycle are ignored
//   push_i       push data_i (call predicted)
//   pop_i        pop the top entry (return predicted)
//   data_i       return address to push, stored bit-exact
//   valid_o      top entry holds a valid address
//   addr_o       top-entry address (0 when invalid)
//   count_o      number of valid entries
//   overflow_o   one-cycle pulse: the previous push discarded a valid bottom entry
//   underflow_o  one-cycle pulse: the previous pop hit an empty stack
module return_addr_stack #(
    parameter int unsigned VLEN  = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_bp_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [VLEN-1:0]            data_i,
    output logic                       valid_o,
    output logic [VLEN-1:0]            addr_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       overflow_o,
    output logic                       underflow_o
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [VLEN-1:0]  addr_q [DEPTH];
    logic [VLEN-1:0]  addr_d [DEPTH];
    logic [CntW-1:0]  count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    always_comb begin
        valid_d     = valid_q;
        addr_d      = addr_q;
        count_d     = count_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;

        if (flush_bp_i) begin
            valid_d = '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_d[i] = '0;
            end
            count_d = '0;
        end else if (push_i && pop_i) begin
            // A call and a return in the same cycle replace the top entry.
            valid_d[0] = 1'b1;
            addr_d[0]  = data_i;
            if (count_q == '0) begin
                count_d = CntW'(1);
            end
        end else if (push_i) begin
            for (int unsigned i = DEPTH - 1; i >= 1; i--) begin
                valid_d[i] = valid_q[i-1];
                addr_d[i]  = addr_q[i-1];
            end
            valid_d[0] = 1'b1;
            addr_d[0]  = data_i;
            // The oldest entry falls off the bottom silently. The flag only reports it.
            overflow_d = valid_q[DEPTH-1];
            if (count_q != CntW'(DEPTH)) begin
                count_d = count_q + CntW'(1);
            end
        end else if (pop_i) begin
            for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                valid_d[i] = valid_q[i+1];
                addr_d[i]  = addr_q[i+1];
            end
            valid_d[DEPTH-1] = 1'b0;
            addr_d[DEPTH-1]  = '0;
            underflow_d      = (count_q == '0);
            if (count_q != '0) begin
                count_d = count_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
            end
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            addr_q      <= addr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Invalid entries always carry address 0, so addr_o reads 0 when the stack is empty.
    assign valid_o     = valid_q[0];
    assign addr_o      = addr_q[0];
    assign count_o     = count_q;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;

endmodule

// File: tb/tb_return_addr_stack.sv
// Bench for return_addr_stack with VLEN=64 and DEPTH=4.
// It runs a directed vector table, then a random stream checked against a bounded-list model.
module tb_return_addr_stack;

    localparam int unsigned VLEN  = 64;
    localparam int unsigned DEPTH = 4;

    logic            clk;
    logic            rst;
    logic            flush;
    logic            push;
    logic            pop;
    logic [VLEN-1:0] data;
    logic            valid;
    logic [VLEN-1:0] addr;
    logic [2:0]      count;
    logic            ovf;
    logic            unf;

    int total;
    int bad;
    int idx;

    return_addr_stack #(
        .VLEN (VLEN),
        .DEPTH(DEPTH)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .flush_bp_i (flush),
        .push_i     (push),
        .pop_i      (pop),
        .data_i     (data),
        .valid_o    (valid),
        .addr_o     (addr),
        .count_o    (count),
        .overflow_o (ovf),
        .underflow_o(unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs applied for one cycle, and the outputs expected after that edge.
    typedef struct {
        logic            rst;
        logic            flush;
        logic            push;
        logic            pop;
        logic [VLEN-1:0] data;
        logic            ev;
        logic [VLEN-1:0] ea;
        logic [2:0]      ec;
        logic            eo;
        logic            eu;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(logic r, logic f, logic pu, logic po, logic [VLEN-1:0] d,
                               logic ev, logic [VLEN-1:0] ea, logic [2:0] ec,
                               logic eo, logic eu);
        vec_t x;
        x.rst = r;  x.flush = f; x.push = pu; x.pop = po; x.data = d;
        x.ev = ev;  x.ea = ea;   x.ec = ec;   x.eo = eo;  x.eu = eu;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%0h want=%0h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic pu, input logic po,
                         input logic [VLEN-1:0] d);
        @(negedge clk);
        rst = r; flush = f; push = pu; pop = po; data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input logic ev, input logic [VLEN-1:0] ea, input logic [2:0] ec,
                             input logic eo, input logic eu);
        chk("valid", VLEN'(valid), VLEN'(ev));
        chk("addr", addr, ea);
        chk("count", VLEN'(count), VLEN'(ec));
        chk("overflow", VLEN'(ovf), VLEN'(eo));
        chk("underflow", VLEN'(unf), VLEN'(eu));
    endtask

    // Reference model: a bounded list with the top at index 0.
    logic [VLEN-1:0] mq[$];
    logic            m_ovf;
    logic            m_unf;

    task automatic model_step(input logic r, input logic f, input logic pu, input logic po,
                              input logic [VLEN-1:0] d);
        m_ovf = 1'b0;
        m_unf = 1'b0;
        if (r || f) begin
            mq.delete();
        end else if (pu && po) begin
            if (mq.size() == 0) mq.push_front(d);
            else mq[0] = d;
        end else if (pu) begin
            mq.push_front(d);
            if (mq.size() > DEPTH) begin
                void'(mq.pop_back());
                m_ovf = 1'b1;
            end
        end else if (po) begin
            if (mq.size() == 0) m_unf = 1'b1;
            else void'(mq.pop_front());
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idx   = 0;
        rst = 1'b0; flush = 1'b0; push = 1'b0; pop = 1'b0; data = '0;

        //             rst  fl   push pop  data            v    addr            cnt  ov   un
        vecs.push_back(v(1, 0, 0, 0, 64'h0,            0, 64'h0,            0, 0, 0));
        // LIFO order
        vecs.push_back(v(0, 0, 1, 0, 64'h1000,         1, 64'h1000,         1, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 64'h2000,         1, 64'h2000,         2, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 64'h3000,         1, 64'h3000,         3, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 64'h0,            1, 64'h2000,         2, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 64'h0,            1, 64'h1000,         1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 64'h0,            0, 64'h0,            0, 0, 0));
        // overflow drops the oldest entry, underflow on an empty pop
        vecs.push_back(v(0, 0, 1, 0, 64'hA1,           1, 64'hA1,           1, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 64'hA2,           1, 64'hA2,           2, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 64'hA3,           1, 64'hA3,           3, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 64'hA4,           1, 64'hA4,           4, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 64'hFEDC_BA98_0000_00A5, 1, 64'hFEDC_BA98_0000_00A5, 4, 1, 0));
        vecs.push_back(v(0, 0, 0, 0, 64'h0,            1, 64'hFEDC_BA98_0000_00A5, 4, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 64'h0,            1, 64'hA4,           3, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 64'h0,            1, 64'hA3,           2, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 64'h0,            1, 64'hA2,           1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 64'h0,            0, 64'h0,            0, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 64'h0,            0, 64'h0,            0, 0, 1));
        vecs.push_back(v(0, 0, 0, 0, 64'h0,            0, 64'h0,            0, 0, 0));
        // simultaneous push+pop replaces the top entry
        vecs.push_back(v(0, 0, 1, 0, 64'h100,          1, 64'h100,          1, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 64'h200,          1, 64'h200,          2, 0, 0));
        vecs.push_back(v(0, 0, 1, 1, 64'h300,          1, 64'h300,          2, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 64'h0,            1, 64'h100,          1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 64'h0,            0, 64'h0,            0, 0, 0));
        vecs.push_back(v(0, 0, 1, 1, 64'h40,           1, 64'h40,           1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 64'h0,            0, 64'h0,            0, 0, 0));
        // flush wins over push, and the next push lands in an empty stack
        vecs.push_back(v(0, 0, 1, 0, 64'h1,            1, 64'h1,            1, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 64'h2,            1, 64'h2,            2, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 64'h3,            1, 64'h3,            3, 0, 0));
        vecs.push_back(v(0, 1, 1, 0, 64'hABC,          0, 64'h0,            0, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 64'h10,           1, 64'h10,           1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 64'h0,            0, 64'h0,            0, 0, 0));
        // reset wins over pop mid-operation
        vecs.push_back(v(0, 0, 1, 0, 64'h11,           1, 64'h11,           1, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 64'h22,           1, 64'h22,           2, 0, 0));
        vecs.push_back(v(1, 0, 0, 1, 64'h0,            0, 64'h0,            0, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 64'h0,            0, 64'h0,            0, 0, 1));
        // reset clears a pending underflow pulse
        vecs.push_back(v(1, 0, 0, 0, 64'h0,            0, 64'h0,            0, 0, 0));

        foreach (vecs[i]) begin
            idx = i;
            drive(vecs[i].rst, vecs[i].flush, vecs[i].push, vecs[i].pop, vecs[i].data);
            check_all(vecs[i].ev, vecs[i].ea, vecs[i].ec, vecs[i].eo, vecs[i].eu);
        end

        // Random stream against the model, starting from reset.
        mq.delete();
        model_step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
        for (int n = 0; n < 10000; n++) begin
            logic            r_r, r_f, r_pu, r_po;
            logic [VLEN-1:0] r_d;
            idx  = 1000 + n;
            r_r  = ($urandom_range(0, 255) == 0);
            r_f  = ($urandom_range(0, 31) == 0);
            r_pu = ($urandom_range(0, 1) == 1);
            r_po = ($urandom_range(0, 1) == 1);
            r_d  = {$urandom, $urandom};
            model_step(r_r, r_f, r_pu, r_po, r_d);
            drive(r_r, r_f, r_pu, r_po, r_d);
            check_all(mq.size() != 0, (mq.size() != 0) ? mq[0] : '0, 3'(mq.size()),
                      m_ovf, m_unf);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
